// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register addresses, Status/Cause bit positions,
// redirect FSM encoding and the timer-interrupt vector.
package cp0_exc_ctrl_pkg;
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam int ST_IE      = 0;
    localparam int ST_EXL     = 1;
    localparam int ST_IM7     = 15;
    localparam int CA_EXC_LO  = 2;
    localparam int CA_IP7     = 15;

    localparam logic [31:0] INT_VEC_DEFAULT = 32'h80000030;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_REDIR = 1'b1
    } cp0_state_e;
endpackage

// File: rtl/cp0_timer.sv
// Free-running Count with Compare match; IP7 latches on a match and is
// cleared by any write to Compare (the write wins over a simultaneous match).
module cp0_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ip7
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 32'd0;
            compare <= 32'hFFFFFFFF;
            ip7     <= 1'b0;
        end else begin
            count <= count_we ? wdata : count + 32'd1;
            if (compare_we)
                compare <= wdata;
            if (compare_we)
                ip7 <= 1'b0;
            else if (count == compare)
                ip7 <= 1'b1;
        end
    end
endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: arbitrates brk / timer interrupt / eret, updates
// Status, Cause and EPC, and issues a one-cycle registered redirect + flush.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter int          EXC_WIDTH = 5,
    parameter logic [31:0] INT_VEC   = INT_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        brk,
    input  logic [31:0] cause_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] brk_vec,
    input  logic        eret,
    input  logic [31:0] mem_pc,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    input  logic [4:0]  mfc0_addr,
    output logic [31:0] mfc0_data,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] status
);
    cp0_state_e           state;
    logic [31:0]          status_q;
    logic [EXC_WIDTH-1:0] exc_code;
    logic [31:0]          epc_q;
    logic [31:0]          count;
    logic [31:0]          compare;
    logic                 ip7;
    logic                 in_run, exl, int_req;
    logic                 take_brk, take_int, take_eret, accept;
    logic [31:0]          target;
    logic [31:0]          cause_rd;
    logic                 unused_cause_bits;

    assign unused_cause_bits = ^cause_in[31:EXC_WIDTH];

    cp0_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_we   (mtc0_we && (mtc0_addr == CP0_COUNT)),
        .compare_we (mtc0_we && (mtc0_addr == CP0_COMPARE)),
        .wdata      (mtc0_data),
        .count      (count),
        .compare    (compare),
        .ip7        (ip7)
    );

    // Events are only sampled in RUN; priority brk > interrupt > eret.
    assign in_run    = (state == ST_RUN);
    assign exl       = status_q[ST_EXL];
    assign int_req   = ip7 & status_q[ST_IM7] & status_q[ST_IE] & ~exl;
    assign take_brk  = in_run & brk;
    assign take_int  = in_run & ~brk & int_req;
    assign take_eret = in_run & ~brk & ~int_req & eret;
    assign accept    = take_brk | take_int | take_eret;

    always_comb begin
        target = 32'd0;
        if (take_brk)
            target = brk_vec;
        else if (take_int)
            target = INT_VEC;
        else if (take_eret)
            target = epc_q;
    end

    always_comb begin
        cause_rd = 32'd0;
        cause_rd[CA_IP7] = ip7;
        cause_rd[CA_EXC_LO +: EXC_WIDTH] = exc_code;
    end

    always_comb begin
        mfc0_data = 32'd0;
        case (mfc0_addr)
            CP0_COUNT:   mfc0_data = count;
            CP0_COMPARE: mfc0_data = compare;
            CP0_STATUS:  mfc0_data = status_q;
            CP0_CAUSE:   mfc0_data = cause_rd;
            CP0_EPC:     mfc0_data = epc_q;
            default:     mfc0_data = 32'd0;
        endcase
    end

    // mtc0 updates come first so a same-cycle event overrides the fields it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            status_q    <= 32'd0;
            exc_code    <= '0;
            epc_q       <= 32'd0;
            redirect    <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            state       <= accept ? ST_REDIR : ST_RUN;
            redirect    <= accept;
            flush       <= accept;
            redirect_pc <= target;
            if (mtc0_we && (mtc0_addr == CP0_STATUS))
                status_q <= mtc0_data;
            if (mtc0_we && (mtc0_addr == CP0_EPC))
                epc_q <= mtc0_data;
            if (take_brk) begin
                exc_code         <= cause_in[EXC_WIDTH-1:0];
                status_q[ST_EXL] <= 1'b1;
                if (!exl)
                    epc_q <= epc_in;
            end else if (take_int) begin
                exc_code         <= '0;
                epc_q            <= mem_pc;
                status_q[ST_EXL] <= 1'b1;
            end else if (take_eret) begin
                status_q[ST_EXL] <= 1'b0;
            end
        end
    end

    assign status = status_q;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: scenario tasks with a redirect-target scoreboard.
module tb_cp0_exc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        brk;
    logic [31:0] cause_in, epc_in, brk_vec;
    logic        eret;
    logic [31:0] mem_pc;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] status;

    int pass_cnt = 0;
    int check_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] d;

    cp0_exc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .brk(brk), .cause_in(cause_in), .epc_in(epc_in),
        .brk_vec(brk_vec), .eret(eret), .mem_pc(mem_pc), .mtc0_we(mtc0_we),
        .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data), .mfc0_addr(mfc0_addr),
        .mfc0_data(mfc0_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .status(status)
    );

    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        mfc0_addr = a;
        #1;
        v = mfc0_data;
    endtask

    task automatic test_reset();
        check_cnt++; if (redirect !== 1'b0 || flush !== 1'b0) $display("FAIL reset_redirect got %0b/%0b exp 0/0", redirect, flush); else pass_cnt++;
        check_cnt++; if (redirect_pc !== 32'd0) $display("FAIL reset_pc got %h exp 0", redirect_pc); else pass_cnt++;
        check_cnt++; if (status !== 32'd0) $display("FAIL reset_status got %h exp 0", status); else pass_cnt++;
        rd(5'd9, d);
        check_cnt++; if (d !== 32'd0) $display("FAIL reset_count got %h exp 0", d); else pass_cnt++;
        rd(5'd11, d);
        check_cnt++; if (d !== 32'hFFFFFFFF) $display("FAIL reset_compare got %h exp ffffffff", d); else pass_cnt++;
        rd(5'd13, d);
        check_cnt++; if (d !== 32'd0) $display("FAIL reset_cause got %h exp 0", d); else pass_cnt++;
        rd(5'd14, d);
        check_cnt++; if (d !== 32'd0) $display("FAIL reset_epc got %h exp 0", d); else pass_cnt++;
        rd(5'd5, d);
        check_cnt++; if (d !== 32'd0) $display("FAIL unmapped_read got %h exp 0", d); else pass_cnt++;
        step();
    endtask

    task automatic test_brk();
        brk = 1'b1; cause_in = 32'd12; epc_in = 32'h00400010; brk_vec = 32'h80000018;
        exp_q.push_back(32'h80000018);
        step();
        brk = 1'b0;
        check_cnt++; if (redirect !== 1'b1 || flush !== 1'b1) $display("FAIL brk_redirect got %0b/%0b exp 1/1", redirect, flush); else pass_cnt++;
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL brk_pc scoreboard empty got %h", redirect_pc);
        else begin exp_pc = exp_q.pop_front(); if (redirect_pc !== exp_pc) $display("FAIL brk_pc got %h exp %h", redirect_pc, exp_pc); else pass_cnt++; end
        rd(5'd14, d);
        check_cnt++; if (d !== 32'h00400010) $display("FAIL brk_epc got %h exp 00400010", d); else pass_cnt++;
        rd(5'd13, d);
        check_cnt++; if (d[6:2] !== 5'd12) $display("FAIL brk_exccode got %0d exp 12", d[6:2]); else pass_cnt++;
        check_cnt++; if (status[1] !== 1'b1) $display("FAIL brk_exl got %0b exp 1", status[1]); else pass_cnt++;
        step();
        check_cnt++; if (redirect !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'd0) $display("FAIL brk_one_cycle got %0b/%0b/%h exp 0/0/0", redirect, flush, redirect_pc); else pass_cnt++;
    endtask

    task automatic test_brk_nested();
        brk = 1'b1; cause_in = 32'd10; epc_in = 32'h00400020; brk_vec = 32'h80000000;
        exp_q.push_back(32'h80000000);
        step();
        brk = 1'b0;
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL nested_pc scoreboard empty got %h", redirect_pc);
        else begin exp_pc = exp_q.pop_front(); if (redirect !== 1'b1 || redirect_pc !== exp_pc) $display("FAIL nested_pc got %0b/%h exp 1/%h", redirect, redirect_pc, exp_pc); else pass_cnt++; end
        rd(5'd14, d);
        check_cnt++; if (d !== 32'h00400010) $display("FAIL nested_epc got %h exp 00400010", d); else pass_cnt++;
        rd(5'd13, d);
        check_cnt++; if (d[6:2] !== 5'd10) $display("FAIL nested_exccode got %0d exp 10", d[6:2]); else pass_cnt++;
        step();
    endtask

    task automatic test_eret();
        eret = 1'b1;
        exp_q.push_back(32'h00400010);
        step();
        eret = 1'b0;
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL eret_pc scoreboard empty got %h", redirect_pc);
        else begin exp_pc = exp_q.pop_front(); if (redirect !== 1'b1 || redirect_pc !== exp_pc) $display("FAIL eret_pc got %0b/%h exp 1/%h", redirect, redirect_pc, exp_pc); else pass_cnt++; end
        check_cnt++; if (status[1] !== 1'b0) $display("FAIL eret_exl got %0b exp 0", status[1]); else pass_cnt++;
        step();
    endtask

    task automatic test_brk_eret();
        brk = 1'b1; eret = 1'b1; cause_in = 32'd13; epc_in = 32'h00400040; brk_vec = 32'h80000018;
        exp_q.push_back(32'h80000018);
        step();
        brk = 1'b0; eret = 1'b0;
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL brk_eret_pc scoreboard empty got %h", redirect_pc);
        else begin exp_pc = exp_q.pop_front(); if (redirect !== 1'b1 || redirect_pc !== exp_pc) $display("FAIL brk_eret_pc got %0b/%h exp 1/%h", redirect, redirect_pc, exp_pc); else pass_cnt++; end
        check_cnt++; if (status[1] !== 1'b1) $display("FAIL brk_eret_exl got %0b exp 1", status[1]); else pass_cnt++;
        rd(5'd14, d);
        check_cnt++; if (d !== 32'h00400040) $display("FAIL brk_eret_epc got %h exp 00400040", d); else pass_cnt++;
        step();
    endtask

    task automatic test_mtc0();
        mtc0_we = 1'b1; mtc0_addr = 5'd13; mtc0_data = 32'hFFFFFFFF;
        step();
        rd(5'd13, d);
        check_cnt++; if (d !== 32'h00000034) $display("FAIL cause_write got %h exp 00000034", d); else pass_cnt++;
        mtc0_addr = 5'd9;
        step();
        mtc0_we = 1'b0;
        rd(5'd9, d);
        check_cnt++; if (d !== 32'hFFFFFFFF) $display("FAIL count_write got %h exp ffffffff", d); else pass_cnt++;
        step();
        rd(5'd9, d);
        check_cnt++; if (d !== 32'd0) $display("FAIL count_wrap got %h exp 0", d); else pass_cnt++;
        rd(5'd13, d);
        check_cnt++; if (d[15] !== 1'b1) $display("FAIL ip7_match got %0b exp 1", d[15]); else pass_cnt++;
        // eret and an mtc0 that sets EXL land on the same edge
        eret = 1'b1; mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_data = 32'h00000002;
        exp_q.push_back(32'h00400040);
        step();
        eret = 1'b0; mtc0_we = 1'b0;
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL mtc0_eret_pc scoreboard empty got %h", redirect_pc);
        else begin exp_pc = exp_q.pop_front(); if (redirect !== 1'b1 || redirect_pc !== exp_pc) $display("FAIL mtc0_eret_pc got %0b/%h exp 1/%h", redirect, redirect_pc, exp_pc); else pass_cnt++; end
        check_cnt++; if (status !== 32'd0) $display("FAIL event_wins got %h exp 0", status); else pass_cnt++;
        step();
    endtask

    task automatic test_timer();
        mem_pc = 32'h00400100;
        mtc0_we = 1'b1; mtc0_addr = 5'd9; mtc0_data = 32'd0;
        step();
        mtc0_addr = 5'd11; mtc0_data = 32'd5;
        step();
        rd(5'd13, d);
        check_cnt++; if (d[15] !== 1'b0) $display("FAIL ip7_clear got %0b exp 0", d[15]); else pass_cnt++;
        mtc0_addr = 5'd12; mtc0_data = 32'h00008001;
        step();
        mtc0_we = 1'b0;
        step(); step(); step();
        rd(5'd9, d);
        check_cnt++; if (d !== 32'd5) $display("FAIL timer_count got %h exp 5", d); else pass_cnt++;
        exp_q.push_back(32'h80000030);
        step();
        rd(5'd13, d);
        check_cnt++; if (d[15] !== 1'b1 || redirect !== 1'b0) $display("FAIL timer_ip7 got %0b/%0b exp 1/0", d[15], redirect); else pass_cnt++;
        step();
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL timer_pc scoreboard empty got %h", redirect_pc);
        else begin exp_pc = exp_q.pop_front(); if (redirect !== 1'b1 || redirect_pc !== exp_pc) $display("FAIL timer_pc got %0b/%h exp 1/%h", redirect, redirect_pc, exp_pc); else pass_cnt++; end
        rd(5'd13, d);
        check_cnt++; if (d[6:2] !== 5'd0) $display("FAIL timer_exccode got %0d exp 0", d[6:2]); else pass_cnt++;
        rd(5'd14, d);
        check_cnt++; if (d !== 32'h00400100) $display("FAIL timer_epc got %h exp 00400100", d); else pass_cnt++;
        check_cnt++; if (status !== 32'h00008003) $display("FAIL timer_status got %h exp 00008003", status); else pass_cnt++;
        mtc0_we = 1'b1; mtc0_addr = 5'd11; mtc0_data = 32'h00001000;
        step();
        mtc0_we = 1'b0;
        rd(5'd11, d);
        check_cnt++; if (d !== 32'h00001000) $display("FAIL redir_mtc0 got %h exp 00001000", d); else pass_cnt++;
        rd(5'd13, d);
        check_cnt++; if (d[15] !== 1'b0 || redirect !== 1'b0) $display("FAIL timer_after got %0b/%0b exp 0/0", d[15], redirect); else pass_cnt++;
    endtask

    task automatic test_redir_ignore();
        eret = 1'b1;
        exp_q.push_back(32'h00400100);
        step();
        eret = 1'b0;
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL ignore_eret_pc scoreboard empty got %h", redirect_pc);
        else begin exp_pc = exp_q.pop_front(); if (redirect !== 1'b1 || redirect_pc !== exp_pc) $display("FAIL ignore_eret_pc got %0b/%h exp 1/%h", redirect, redirect_pc, exp_pc); else pass_cnt++; end
        brk = 1'b1; cause_in = 32'd7; epc_in = 32'h00400999; brk_vec = 32'h80000018;
        step();
        brk = 1'b0;
        check_cnt++; if (redirect !== 1'b0 || flush !== 1'b0) $display("FAIL ignore_redirect got %0b/%0b exp 0/0", redirect, flush); else pass_cnt++;
        rd(5'd14, d);
        check_cnt++; if (d !== 32'h00400100) $display("FAIL ignore_epc got %h exp 00400100", d); else pass_cnt++;
        check_cnt++; if (status[1] !== 1'b0) $display("FAIL ignore_exl got %0b exp 0", status[1]); else pass_cnt++;
        step();
        check_cnt++; if (redirect !== 1'b0) $display("FAIL ignore_replay got %0b exp 0", redirect); else pass_cnt++;
    endtask

    task automatic test_reset_mid_redir();
        brk = 1'b1; cause_in = 32'd8; epc_in = 32'h00400200; brk_vec = 32'h80000018;
        exp_q.push_back(32'h80000018);
        step();
        brk = 1'b0;
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL rst_brk_pc scoreboard empty got %h", redirect_pc);
        else begin exp_pc = exp_q.pop_front(); if (redirect !== 1'b1 || redirect_pc !== exp_pc) $display("FAIL rst_brk_pc got %0b/%h exp 1/%h", redirect, redirect_pc, exp_pc); else pass_cnt++; end
        #2;
        rst_n = 1'b0;
        #1;
        check_cnt++; if (redirect !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'd0) $display("FAIL async_drop got %0b/%0b/%h exp 0/0/0", redirect, flush, redirect_pc); else pass_cnt++;
        rd(5'd11, d);
        check_cnt++; if (d !== 32'hFFFFFFFF) $display("FAIL rst_compare got %h exp ffffffff", d); else pass_cnt++;
        rd(5'd9, d);
        check_cnt++; if (d !== 32'd0) $display("FAIL rst_count got %h exp 0", d); else pass_cnt++;
        #5;
        rst_n = 1'b1;
        step();
        check_cnt++; if (redirect !== 1'b0 || status !== 32'd0) $display("FAIL rst_replay got %0b/%h exp 0/0", redirect, status); else pass_cnt++;
        check_cnt++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; brk = 1'b0; cause_in = 32'd0; epc_in = 32'd0; brk_vec = 32'd0;
        eret = 1'b0; mem_pc = 32'd0; mtc0_we = 1'b0; mtc0_addr = 5'd0; mtc0_data = 32'd0;
        mfc0_addr = 5'd0;
        #25;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_brk();
        test_brk_nested();
        test_eret();
        test_brk_eret();
        test_mtc0();
        test_timer();
        test_redir_ignore();
        test_reset_mid_redir();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
